// File: rtl/eth_rx_cmd_depacketizer.sv
// Strips the L2 header from MAC RX frames addressed to this node and packs the
// payload big-endian into 32-bit command words, counting forwarded and dropped frames.
module eth_rx_cmd_depacketizer #(
    parameter logic [47:0] DEST_MAC     = 48'h5a0102030405,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter int          HDR_BYTES    = 14,
    parameter int          CNT_W        = 16
) (
    input  logic             axi_tclk_i,
    input  logic             axi_tresetn_i,
    input  logic             enable_rx_decode,
    input  logic [7:0]       rx_axis_tdata,
    input  logic             rx_axis_tvalid,
    input  logic             rx_axis_tlast,
    input  logic             rx_axis_tuser,
    output logic             rx_axis_tready,
    output logic [31:0]      cmd_axis_tdata,
    output logic             cmd_axis_tvalid,
    output logic             cmd_axis_tlast,
    output logic             cmd_axis_tuser,
    input  logic             cmd_axis_tready,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] drop_count
);
    localparam int HC_W = $clog2(HDR_BYTES);

    typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DROP} state_t;
    state_t state, state_nxt;

    logic [HC_W-1:0] hc;
    logic            en_q, ucast_mis, bcast_mis;
    logic [1:0]      lane;
    logic [31:0]     pack_reg, word_nxt;
    logic            pack_full, pend_last, pend_user;
    logic [47:0]     mac_sh;
    logic            byte_xfer, out_free, hdr_last, hdr_end, accept;
    logic            byte_in_mac, u_mis_byte, b_mis_byte, word_done;

    assign rx_axis_tready = (state == S_PAYLOAD) ? ~pack_full : 1'b1;
    assign byte_xfer      = rx_axis_tvalid & rx_axis_tready;
    assign out_free       = ~cmd_axis_tvalid | cmd_axis_tready;
    assign hdr_last       = (hc == HC_W'(HDR_BYTES - 1));
    assign hdr_end        = (state == S_HDR) & byte_xfer & ~rx_axis_tlast & hdr_last;
    assign accept         = en_q & (~ucast_mis | (ACCEPT_BCAST & ~bcast_mis));
    assign word_done      = (state == S_PAYLOAD) & byte_xfer & ((lane == 2'd3) | rx_axis_tlast);

    // Left-shifting the MAC by the header index puts the expected byte on top
    assign mac_sh      = DEST_MAC << {hc, 3'b000};
    assign byte_in_mac = (hc < HC_W'(6));
    assign u_mis_byte  = byte_in_mac & (rx_axis_tdata != mac_sh[47:40]);
    assign b_mis_byte  = byte_in_mac & (rx_axis_tdata != 8'hff);

    always_comb begin
        word_nxt = pack_reg;
        case (lane)
            2'd0: word_nxt[31:24] = rx_axis_tdata;
            2'd1: word_nxt[23:16] = rx_axis_tdata;
            2'd2: word_nxt[15:8]  = rx_axis_tdata;
            2'd3: word_nxt[7:0]   = rx_axis_tdata;
        endcase
    end

    always_ff @(posedge axi_tclk_i or posedge axi_tresetn_i) begin
        if (axi_tresetn_i) state <= S_HDR;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HDR: begin
                if (hdr_end) state_nxt = accept ? S_PAYLOAD : S_DROP;
            end
            S_PAYLOAD, S_DROP: begin
                if (byte_xfer & rx_axis_tlast) state_nxt = S_HDR;
            end
            default: state_nxt = S_HDR;
        endcase
    end

    always_ff @(posedge axi_tclk_i or posedge axi_tresetn_i) begin
        if (axi_tresetn_i) begin
            hc              <= '0;
            en_q            <= 1'b0;
            ucast_mis       <= 1'b0;
            bcast_mis       <= 1'b0;
            lane            <= 2'd0;
            pack_reg        <= '0;
            pack_full       <= 1'b0;
            pend_last       <= 1'b0;
            pend_user       <= 1'b0;
            cmd_axis_tdata  <= '0;
            cmd_axis_tvalid <= 1'b0;
            cmd_axis_tlast  <= 1'b0;
            cmd_axis_tuser  <= 1'b0;
            frame_count     <= '0;
            drop_count      <= '0;
        end else begin
            if ((state == S_HDR) && byte_xfer) begin
                hc        <= (rx_axis_tlast || hdr_last) ? '0 : hc + 1'b1;
                ucast_mis <= ((hc == '0) ? 1'b0 : ucast_mis) | u_mis_byte;
                bcast_mis <= ((hc == '0) ? 1'b0 : bcast_mis) | b_mis_byte;
                if (hc == '0) en_q <= enable_rx_decode;
            end

            if (byte_xfer && rx_axis_tlast && (state != S_PAYLOAD))
                drop_count <= drop_count + 1'b1;
            if (byte_xfer && rx_axis_tlast && (state == S_PAYLOAD))
                frame_count <= frame_count + 1'b1;

            if ((state == S_PAYLOAD) && byte_xfer)
                lane <= rx_axis_tlast ? 2'd0 : lane + 1'b1;

            // pack_reg is kept zeroed between words so a short final word pads with 0
            if (word_done) begin
                if (out_free) begin
                    pack_reg <= '0;
                end else begin
                    pack_reg  <= word_nxt;
                    pack_full <= 1'b1;
                    pend_last <= rx_axis_tlast;
                    pend_user <= rx_axis_tlast & rx_axis_tuser;
                end
            end else if ((state == S_PAYLOAD) && byte_xfer) begin
                pack_reg <= word_nxt;
            end else if (pack_full && out_free) begin
                pack_reg  <= '0;
                pack_full <= 1'b0;
            end

            if (pack_full && out_free) begin
                cmd_axis_tdata  <= pack_reg;
                cmd_axis_tvalid <= 1'b1;
                cmd_axis_tlast  <= pend_last;
                cmd_axis_tuser  <= pend_user;
            end else if (word_done && out_free) begin
                cmd_axis_tdata  <= word_nxt;
                cmd_axis_tvalid <= 1'b1;
                cmd_axis_tlast  <= rx_axis_tlast;
                cmd_axis_tuser  <= rx_axis_tlast & rx_axis_tuser;
            end else if (cmd_axis_tready) begin
                cmd_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_cmd_depacketizer.sv
// Directed bench for eth_rx_cmd_depacketizer: address filtering, packing,
// backpressure, frame error passthrough and mid-frame reset.
module tb_eth_rx_cmd_depacketizer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [7:0]  rx_tdata = '0;
    logic        rx_tvalid = 1'b0, rx_tlast = 1'b0, rx_tuser = 1'b0;
    logic        rx_tready, nb_rx_tready;
    logic [31:0] c_tdata, nb_tdata;
    logic        c_tvalid, c_tlast, c_tuser, nb_tvalid, nb_tlast, nb_tuser;
    logic        c_tready = 1'b1;
    logic [15:0] frame_count, drop_count, nb_frame_count, nb_drop_count;

    int chk = 0, pass = 0;
    int rdy_low = 0, stall_err = 0, nb_xfer = 0;
    logic [7:0]  frm[$];
    logic [31:0] mon_data[$];
    logic        mon_last[$], mon_user[$];
    logic        prev_stall = 1'b0, prev_last, prev_user;
    logic [31:0] prev_data;

    always #5 clk = ~clk;

    eth_rx_cmd_depacketizer u_dut (
        .axi_tclk_i(clk), .axi_tresetn_i(rst), .enable_rx_decode(enable),
        .rx_axis_tdata(rx_tdata), .rx_axis_tvalid(rx_tvalid), .rx_axis_tlast(rx_tlast),
        .rx_axis_tuser(rx_tuser), .rx_axis_tready(rx_tready),
        .cmd_axis_tdata(c_tdata), .cmd_axis_tvalid(c_tvalid), .cmd_axis_tlast(c_tlast),
        .cmd_axis_tuser(c_tuser), .cmd_axis_tready(c_tready),
        .frame_count(frame_count), .drop_count(drop_count));

    eth_rx_cmd_depacketizer #(.ACCEPT_BCAST(1'b0)) u_dut_nb (
        .axi_tclk_i(clk), .axi_tresetn_i(rst), .enable_rx_decode(enable),
        .rx_axis_tdata(rx_tdata), .rx_axis_tvalid(rx_tvalid), .rx_axis_tlast(rx_tlast),
        .rx_axis_tuser(rx_tuser), .rx_axis_tready(nb_rx_tready),
        .cmd_axis_tdata(nb_tdata), .cmd_axis_tvalid(nb_tvalid), .cmd_axis_tlast(nb_tlast),
        .cmd_axis_tuser(nb_tuser), .cmd_axis_tready(c_tready),
        .frame_count(nb_frame_count), .drop_count(nb_drop_count));

    // Output monitor: collects transferred words and flags any change while stalled
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!c_tvalid || c_tdata !== prev_data ||
                               c_tlast !== prev_last || c_tuser !== prev_user))
                stall_err++;
            if (c_tvalid && c_tready) begin
                mon_data.push_back(c_tdata);
                mon_last.push_back(c_tlast);
                mon_user.push_back(c_tuser);
            end
            if (nb_tvalid && c_tready) nb_xfer++;
            prev_stall = c_tvalid && !c_tready;
            prev_data  = c_tdata;
            prev_last  = c_tlast;
            prev_user  = c_tuser;
        end
    end

    task automatic mk_hdr(input logic [47:0] dst);
        logic [47:0] d;
        frm.delete();
        d = dst;
        for (int i = 0; i < 6; i++) frm.push_back(d[47-8*i -: 8]);
        frm.push_back(8'h00); frm.push_back(8'h0a); frm.push_back(8'h35);
        frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h01);
        frm.push_back(8'h08); frm.push_back(8'h00);
    endtask

    task automatic clear_mon();
        mon_data.delete(); mon_last.delete(); mon_user.delete();
    endtask

    task automatic send_frame(input bit with_last, input bit user);
        for (int i = 0; i < frm.size(); i++) begin
            int  waited = 0;
            bit  done = 0;
            rx_tdata  = frm[i];
            rx_tvalid = 1'b1;
            rx_tlast  = with_last && (i == frm.size() - 1);
            rx_tuser  = user && rx_tlast;
            while (!done) begin
                @(negedge clk);
                done = rx_tready;
                if (!done) rdy_low++;
                @(posedge clk); #1;
                waited++;
                if (!done && waited > 2000) begin
                    chk++;
                    $display("FAIL send_timeout byte %0d got tready=0 required 1 within 2000 cycles", i);
                    rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
                    return;
                end
            end
        end
        rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
    endtask

    task automatic wait_words(input int n);
        for (int k = 0; k < 200 && mon_data.size() < n; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        chk++; if (c_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b required 0", c_tvalid); else pass++;
        chk++; if (rx_tready !== 1'b1) $display("FAIL reset_tready got %b required 1", rx_tready); else pass++;
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk++; if (c_tdata !== 32'h0) $display("FAIL reset_tdata got %h required 0", c_tdata); else pass++;
        chk++; if ({c_tlast, c_tuser} !== 2'b00) $display("FAIL reset_tlast_tuser got %b required 00", {c_tlast, c_tuser}); else pass++;
        chk++; if (frame_count !== 16'd0 || drop_count !== 16'd0)
            $display("FAIL reset_counts got %0d/%0d required 0/0", frame_count, drop_count); else pass++;
    endtask

    task automatic test_basic();
        logic [31:0] ew[3] = '{32'h57575757, 32'h0000000a, 32'h00000002};
        clear_mon();
        mk_hdr(48'h5a0102030405);
        frm.push_back(8'h57); frm.push_back(8'h57); frm.push_back(8'h57); frm.push_back(8'h57);
        frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h0a);
        frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h02);
        send_frame(1, 0);
        chk++; if (c_tvalid !== 1'b1 || c_tdata !== 32'h00000002 || c_tlast !== 1'b1)
            $display("FAIL basic_latency got v=%b d=%h l=%b required v=1 d=00000002 l=1", c_tvalid, c_tdata, c_tlast);
        else pass++;
        wait_words(3);
        chk++; if (mon_data.size() !== 3) $display("FAIL basic_count got %0d required 3", mon_data.size()); else pass++;
        for (int i = 0; i < 3; i++) begin
            chk++;
            if (i >= mon_data.size() || mon_data[i] !== ew[i] || mon_last[i] !== (i == 2))
                $display("FAIL basic_word%0d got %h required %h last=%0d", i,
                         (i < mon_data.size()) ? mon_data[i] : 32'hx, ew[i], (i == 2));
            else pass++;
        end
        chk++; if (frame_count !== 16'd1 || drop_count !== 16'd0)
            $display("FAIL basic_counts got %0d/%0d required 1/0", frame_count, drop_count); else pass++;
    endtask

    task automatic test_drop();
        clear_mon();
        rdy_low = 0;
        mk_hdr(48'h5a0102030406);
        for (int i = 0; i < 12; i++) frm.push_back(8'(i));
        send_frame(1, 0);
        mk_hdr(48'h5a0102030405);
        while (frm.size() > 10) void'(frm.pop_back());
        send_frame(1, 0);
        enable = 1'b0;
        mk_hdr(48'h5a0102030405);
        for (int i = 0; i < 8; i++) frm.push_back(8'h33);
        send_frame(1, 0);
        enable = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk++; if (mon_data.size() !== 0) $display("FAIL drop_no_output got %0d words required 0", mon_data.size()); else pass++;
        chk++; if (drop_count !== 16'd3) $display("FAIL drop_count got %0d required 3", drop_count); else pass++;
        chk++; if (frame_count !== 16'd1) $display("FAIL drop_frame_count got %0d required 1", frame_count); else pass++;
        chk++; if (rdy_low !== 0) $display("FAIL drop_tready_low got %0d cycles required 0", rdy_low); else pass++;
    endtask

    task automatic test_bcast();
        int nb0;
        clear_mon();
        nb0 = nb_xfer;
        mk_hdr(48'hffffffffffff);
        frm.push_back(8'h11); frm.push_back(8'h22); frm.push_back(8'h33);
        frm.push_back(8'h44); frm.push_back(8'h55);
        send_frame(1, 0);
        wait_words(2);
        chk++; if (mon_data.size() !== 2) $display("FAIL bcast_count got %0d required 2", mon_data.size()); else pass++;
        chk++; if (mon_data.size() < 2 || mon_data[0] !== 32'h11223344 || mon_last[0] !== 1'b0)
            $display("FAIL bcast_word0 got %h required 11223344", (mon_data.size() > 0) ? mon_data[0] : 32'hx); else pass++;
        chk++; if (mon_data.size() < 2 || mon_data[1] !== 32'h55000000 || mon_last[1] !== 1'b1)
            $display("FAIL bcast_word1 got %h required 55000000 with tlast", (mon_data.size() > 1) ? mon_data[1] : 32'hx); else pass++;
        chk++; if (frame_count !== 16'd2) $display("FAIL bcast_frame_count got %0d required 2", frame_count); else pass++;
        chk++; if (nb_drop_count !== 16'd4 || nb_frame_count !== 16'd1)
            $display("FAIL nobcast_counts got %0d/%0d required drop 4 frame 1", nb_drop_count, nb_frame_count); else pass++;
        chk++; if (nb_xfer !== nb0) $display("FAIL nobcast_output got %0d words required 0", nb_xfer - nb0); else pass++;
    endtask

    task automatic test_backpressure();
        bit tx_done = 0;
        int bad = 0;
        clear_mon();
        rdy_low = 0;
        stall_err = 0;
        mk_hdr(48'h5a0102030405);
        for (int j = 0; j < 64; j++) frm.push_back(8'(j * 3 + 1));
        fork
            begin
                send_frame(1, 0);
                tx_done = 1;
            end
            begin
                for (int c = 0; c < 4000; c++) begin
                    c_tready = (c >= 32) && (((c - 32) % 4) == 0);
                    @(posedge clk); #1;
                    if (tx_done && mon_data.size() >= 16) break;
                end
                c_tready = 1'b1;
            end
        join
        repeat (3) @(posedge clk); #1;
        chk++; if (mon_data.size() !== 16) $display("FAIL bp_count got %0d required 16", mon_data.size()); else pass++;
        for (int k = 0; k < 16 && k < mon_data.size(); k++) begin
            logic [31:0] e;
            e = {8'(12*k + 1), 8'(12*k + 4), 8'(12*k + 7), 8'(12*k + 10)};
            if (mon_data[k] !== e || mon_last[k] !== (k == 15)) begin
                bad++;
                $display("FAIL bp_word%0d got %h last=%b required %h last=%0d", k, mon_data[k], mon_last[k], e, (k == 15));
            end
        end
        chk++; if (bad !== 0) $display("FAIL bp_words got %0d bad words required 0", bad); else pass++;
        chk++; if (stall_err !== 0) $display("FAIL bp_stable got %0d unstable cycles required 0", stall_err); else pass++;
        chk++; if (rdy_low == 0) $display("FAIL bp_tready_deassert got 0 low cycles required >0"); else pass++;
        chk++; if (frame_count !== 16'd3) $display("FAIL bp_frame_count got %0d required 3", frame_count); else pass++;
    endtask

    task automatic test_tuser();
        clear_mon();
        mk_hdr(48'h5a0102030405);
        for (int i = 1; i <= 6; i++) frm.push_back(8'(i));
        send_frame(1, 1);
        wait_words(2);
        chk++; if (mon_data.size() < 2 || mon_data[0] !== 32'h01020304 || mon_user[0] !== 1'b0)
            $display("FAIL tuser_word0 got %h required 01020304 tuser 0", (mon_data.size() > 0) ? mon_data[0] : 32'hx); else pass++;
        chk++; if (mon_data.size() < 2 || mon_data[1] !== 32'h05060000 || mon_last[1] !== 1'b1 || mon_user[1] !== 1'b1)
            $display("FAIL tuser_word1 got %h required 05060000 tlast 1 tuser 1", (mon_data.size() > 1) ? mon_data[1] : 32'hx); else pass++;
        chk++; if (frame_count !== 16'd4) $display("FAIL tuser_frame_count got %0d required 4", frame_count); else pass++;
    endtask

    task automatic test_reset_mid();
        mk_hdr(48'h5a0102030405);
        for (int i = 0; i < 6; i++) frm.push_back(8'hc0 + 8'(i));
        send_frame(0, 0);
        rst = 1'b1;
        #1;
        clear_mon();
        chk++; if (c_tvalid !== 1'b0 || c_tdata !== 32'h0 || c_tlast !== 1'b0)
            $display("FAIL rstmid_outputs got v=%b d=%h l=%b required all 0", c_tvalid, c_tdata, c_tlast); else pass++;
        chk++; if (frame_count !== 16'd0 || drop_count !== 16'd0 || rx_tready !== 1'b1)
            $display("FAIL rstmid_counts got %0d/%0d tready=%b required 0/0 tready=1", frame_count, drop_count, rx_tready); else pass++;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        mk_hdr(48'h5a0102030405);
        for (int i = 1; i <= 8; i++) frm.push_back(8'ha0 + 8'(i));
        send_frame(1, 0);
        wait_words(2);
        chk++; if (mon_data.size() !== 2) $display("FAIL rstmid_count got %0d required 2", mon_data.size()); else pass++;
        chk++; if (mon_data.size() < 2 || mon_data[0] !== 32'ha1a2a3a4 || mon_data[1] !== 32'ha5a6a7a8 ||
                   mon_last[0] !== 1'b0 || mon_last[1] !== 1'b1)
            $display("FAIL rstmid_words got %h %h required a1a2a3a4 a5a6a7a8",
                     (mon_data.size() > 0) ? mon_data[0] : 32'hx, (mon_data.size() > 1) ? mon_data[1] : 32'hx);
        else pass++;
        chk++; if (frame_count !== 16'd1 || drop_count !== 16'd0)
            $display("FAIL rstmid_after_counts got %0d/%0d required 1/0", frame_count, drop_count); else pass++;
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_drop();
        test_bcast();
        test_backpressure();
        test_tuser();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule

// File: doc/eth_rx_cmd_depacketizer.md
Name: eth_rx_cmd_depacketizer

Overview:
Receive-side stage that feeds axi_rx_command_gen. It accepts 8-bit Ethernet frames from the MAC RX AXI-Stream and checks the destination MAC. It strips the 14-byte L2 header and packs the payload big-endian into 32-bit words on the cmd_axis stream, with tlast marking the last word of each command frame. Frames addressed elsewhere, runt frames, and frames arriving while disabled are discarded and counted.

Parameters:
DEST_MAC, 48'h5a0102030405, accepted unicast destination MAC; byte 0 on the wire = bits [47:40]
ACCEPT_BCAST, 1, 1 = also accept FF:FF:FF:FF:FF:FF
HDR_BYTES, 14, L2 header length stripped before the payload
CNT_W, 16, width of the frame and drop counters

Ports:
axi_tclk_i  in  1  clock
axi_tresetn_i  in  1  reset, asynchronous, active-high
enable_rx_decode  in  1  sampled at the first header byte; 0 = drop the frame
rx_axis_tdata  in  8  MAC RX byte
rx_axis_tvalid  in  1  byte valid
rx_axis_tlast  in  1  last byte of frame
rx_axis_tuser  in  1  MAC frame error, valid with tlast
rx_axis_tready  out  1  byte accepted
cmd_axis_tdata  out  32  packed payload word
cmd_axis_tvalid  out  1  word valid
cmd_axis_tlast  out  1  last word of frame
cmd_axis_tuser  out  1  frame error flag, valid with tlast
cmd_axis_tready  in  1  downstream ready
frame_count  out  CNT_W  frames forwarded, wrapping
drop_count  out  CNT_W  frames discarded, wrapping

Behaviour:
- Reset: all outputs 0 except rx_axis_tready=1. State HDR, header counter 0, byte lane 0.
- A byte transfers when rx_axis_tvalid & rx_axis_tready. A word transfers when cmd_axis_tvalid & cmd_axis_tready.
- State HDR: tready=1. Counter hc runs 0..13. For bytes 0..5, mismatch is accumulated against DEST_MAC byte hc and against 0xFF (bcast).
  - enable_rx_decode is captured at hc=0.
  - tlast at any hc ≤ 13 → runt: drop_count+1, stay in HDR, hc←0.
  - At hc=13 without tlast: if enabled & (ucast match | (ACCEPT_BCAST & bcast match)) → PAYLOAD; else → DROP.
- State DROP: tready=1, bytes discarded. At tlast: drop_count+1 → HDR.
- State PAYLOAD: bytes pack into pack_reg. Lane 0 goes to [31:24], lane 3 to [7:0].
  - Word complete when lane 3 is written, or at tlast. On a tlast partial word, the unfilled lanes are 0.
  - The completed word, tlast and tuser move to the output register in the same cycle if the output register is empty or is being drained that cycle. Otherwise pack_full=1.
  - rx_axis_tready = ~pack_full. pack_full clears when the output register accepts the pending word.
  - On tlast: frame_count+1 when the word moves to pack/out stage, then → HDR.
- Output register: cmd_axis_tvalid held until tready. Data, tlast and tuser are stable while valid & ~ready.
- Latency: last byte of a word in → cmd_axis_tvalid 1 cycle later with no backpressure. Sustained throughput is 1 byte/cycle.
- Frame error: tuser at tlast sets cmd_axis_tuser on the final word. The word is still forwarded and frame_count still increments. Errored frames in HDR/DROP count only as drops.
- Counters wrap at 2^CNT_W. Simultaneous frame end and reset: reset wins.
- Reset mid-frame: all state cleared, and no tlast is emitted for the truncated frame. Any residual bytes after reset are treated as a new header.
- enable_rx_decode changes mid-frame have no effect on the current frame.

Test Plan:
- Frame with dst 5a0102030405, src 000a35000001, type 0800, payload 57 57 57 57 00 00 00 0a 00 00 00 02 → cmd words 57575757, 0000000a, 00000002 (tlast on the third), frame_count=1, drop_count=0.
- Same frame with dst 5a0102030406, then a 10-byte runt, then a frame with enable_rx_decode=0 → no cmd output, drop_count=3, rx_axis_tready stays 1.
- Broadcast dst with 5-byte payload 11 22 33 44 55 → words 11223344, 55000000 (tlast). With ACCEPT_BCAST=0 → dropped.
- 64-byte payload with cmd_axis_tready toggling 32-low / 1-high / 3-low → rx_axis_tready deasserts, all 16 words arrive in order, no loss or duplication, data stable under stall.
- rx_axis_tuser=1 on tlast of an accepted frame → final word has cmd_axis_tuser=1. Assert axi_tresetn_i mid-payload → outputs zero at once, and the next clean frame is forwarded correctly.
